strela_input_stream_node: RTL and testbench
===========================================

# strela_input_stream_node

- Input memory node of the STRELA CGRA; one instance per input port.
- Takes the per-node address, size and stride programmed in the control/status registers, plus the start-execution pulse.
- Issues strided 32-bit read requests on an OBI-style bus and buffers responses in a small FIFO.
- Presents the words to the CGRA input port over a valid/ready handshake and reports completion back to the status register.

## Interface
Parameters:
- DATA_WIDTH, 32, width of memory data and stream data
- FIFO_DEPTH, 4, response buffer entries; power of two, ≥2; also bounds outstanding reads

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  single-cycle start pulse (start-execution strobe)
- base_addr_i  in  32  byte address of first word
- size_i  in  16  transfer length in bytes
- stride_i  in  16  byte increment between consecutive words
- mem_req_o  out  1  read request
- mem_addr_o  out  32  request address
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  DATA_WIDTH  read data
- data_o  out  DATA_WIDTH  stream data to CGRA
- valid_o  out  1  stream data valid
- ready_i  in  1  CGRA accepts data
- busy_o  out  1  transfer in progress
- done_o  out  1  sticky completion flag
- stall_o  out  1  busy, and the FIFO is empty or the CGRA is not ready (feeds the stall cycle counter)

## Operation
States:
- IDLE: waiting for a start pulse.
- RUN: issuing read requests.
- DRAIN: all requests granted; waiting for responses and for the FIFO to empty.

Start and parameter latching:
- start_i in IDLE latches base_addr_i, stride_i and words = size_i >> 2 (low two bits ignored), clears done_o, and moves to RUN.
- start_i outside IDLE is ignored.
- If words = 0, the block moves IDLE → DRAIN → IDLE, sets done_o, and issues no request.

Addressing:
- Address of word k = base + k*stride, modulo 2^32; wrap past 0xFFFF_FFFC is silent.
- stride 0 is legal and re-reads the same address.

Request issue (RUN):
- mem_req_o is asserted when credits > 0, where credits = FIFO_DEPTH − outstanding − fifo_count.
- Once asserted, mem_req_o and mem_addr_o hold until mem_gnt_i.
- On a grant, the issued count is incremented.
- When issued = words, the state moves to DRAIN.

Responses:
- Responses return in order; each mem_rvalid_i pushes mem_rdata_i into the FIFO and decrements outstanding.
- mem_rvalid_i with outstanding = 0 is dropped, e.g. a stale response after reset.
- The credit rule guarantees the FIFO never overflows; there is no full-drop path.

Stream output:
- valid_o = FIFO not empty; data_o = FIFO head.
- On valid_o & ready_i the FIFO pops and the delivered count increments.

Completion:
- DRAIN → IDLE when delivered = words.
- done_o is set on that transition and stays high until the next accepted start or reset.

Flags:
- busy_o = state ≠ IDLE.

Simultaneous events:
- A grant, a response and a pop in the same cycle all take effect; credits update by the net change.
- Push and pop on a non-empty FIFO in the same cycle keeps the count unchanged.

Reset:
- rst_i mid-transfer aborts immediately: state IDLE, counters 0, FIFO emptied.
- Responses still in flight on the bus are then discarded by the outstanding = 0 rule.

## Timing
- Reset values: mem_req_o 0, mem_addr_o 0, data_o 0, valid_o 0, busy_o 0, done_o 0, stall_o 0.
- start_i sampled at cycle 0 → mem_req_o high with mem_addr_o = base at cycle 1.
- Grant at cycle t → next request (if credit) at cycle t+1 with the next address.
  - Back-to-back grants give one request per cycle.
- mem_rvalid_i at cycle t → valid_o high at cycle t+1 (FIFO registered write).
- Last pop at cycle t → busy_o 0 and done_o 1 at cycle t+1.
- Peak throughput: one word per cycle when gnt is immediate, rvalid latency ≤ FIFO_DEPTH−1, and ready_i is held high.

## Structure
- Shared package strela_pkg holds:
  - the node state enum;
  - the OBI read request/response typedefs;
  - WORD_BYTES = 4.
- One sub-module: strela_sync_fifo (parameterised width/depth, push/pop/full/empty/count, sync active-high reset).
- All address and counter logic is in the top module.

## Test plan
- base 0x8000_0000, size 80, stride 4, gnt and rvalid next cycle, ready_i high → 20 words at 0x8000_0000..0x8000_004C in order, done_o 1 exactly one cycle after the 20th pop.
- size 0 start → no mem_req_o ever asserted; done_o 1 within 2 cycles.
- FIFO_DEPTH 4, ready_i low for 20 cycles → exactly 4 requests granted, mem_req_o then low, no data lost once ready_i rises.
- base 0xFFFF_FFF8, stride 4, size 16 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
- Random gnt stall → mem_addr_o stable while mem_req_o high and not granted; second start_i while busy → ignored, word count unchanged.
- rst_i asserted with 2 reads outstanding, then 2 stale rvalids → FIFO stays empty, valid_o 0, busy_o 0, done_o 0.

Source files
------------

// File: rtl/strela_pkg.sv
// Shared types and constants for the STRELA input stream node.
package strela_pkg;

  localparam int WORD_BYTES = 4;
  localparam int WORD_SHIFT = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } node_state_e;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_rsp_t;

  // Byte address of the next strided word; wraps silently modulo 2^32.
  function automatic logic [31:0] next_word_addr(logic [31:0] addr, logic [15:0] stride);
    return addr + {16'h0000, stride};
  endfunction

endpackage

// File: rtl/strela_sync_fifo.sv
// Small synchronous FIFO with combinational head; depth must be a power of two.
module strela_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only honoured when a pop frees the slot that cycle.
  always_comb begin
    do_push  = push_i & (~full_o | pop_i);
    do_pop   = pop_i & ~empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/strela_input_stream_node.sv
// STRELA CGRA input memory node: strided OBI reads buffered into a stream port.
//   state    | meaning
//   ST_IDLE  | waiting for start_i
//   ST_RUN   | issuing read requests
//   ST_DRAIN | all requests granted; waiting for responses and FIFO to empty
module strela_input_stream_node
  import strela_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [31:0]           base_addr_i,
  input  logic [15:0]           size_i,
  input  logic [15:0]           stride_i,
  output logic                  mem_req_o,
  output logic [31:0]           mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  stall_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  node_state_e state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] stride_q, stride_d;
  logic [15:0] words_q, words_d;
  logic [15:0] issued_q, issued_d;
  logic [15:0] delivered_q, delivered_d;
  logic [CW-1:0] outst_q, outst_d;
  logic done_q, done_d;

  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty, fifo_full;
  logic [DATA_WIDTH-1:0] fifo_head;
  obi_req_t              req;
  logic                  gnt_acc, push, pop;
  logic [15:0]           start_words;

  // Outstanding reads plus buffered words never exceed the FIFO depth.
  always_comb begin
    req.req     = (state_q == ST_RUN) && ((outst_q + fifo_count) < DEPTH_C) && !fifo_full;
    req.addr    = addr_q;
    gnt_acc     = req.req & mem_gnt_i;
    push        = mem_rvalid_i & (outst_q != '0);
    pop         = ~fifo_empty & ready_i;
    start_words = size_i >> WORD_SHIFT;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    stride_d    = stride_q;
    words_d     = words_q;
    issued_d    = issued_q;
    delivered_d = delivered_q + 16'(pop);
    outst_d     = outst_q + CW'(gnt_acc) - CW'(push);
    done_d      = done_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d      = base_addr_i;
          stride_d    = stride_i;
          words_d     = start_words;
          issued_d    = '0;
          delivered_d = '0;
          done_d      = 1'b0;
          state_d     = (start_words == '0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (gnt_acc) begin
          issued_d = issued_q + 16'd1;
          addr_d   = next_word_addr(addr_q, stride_q);
          if (issued_q + 16'd1 == words_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Include this cycle's pop so done lands one cycle after the last pop.
        if (delivered_d == words_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      stride_q    <= '0;
      words_q     <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      outst_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      stride_q    <= stride_d;
      words_q     <= words_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      outst_q     <= outst_d;
      done_q      <= done_d;
    end
  end

  strela_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (mem_rdata_i),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign mem_req_o  = req.req;
  assign mem_addr_o = req.addr;
  assign valid_o    = ~fifo_empty;
  assign data_o     = fifo_empty ? '0 : fifo_head;
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = done_q;
  assign stall_o    = busy_o & (fifo_empty | ~ready_i);

endmodule

// File: tb/tb_strela_input_stream_node.sv
// Randomized bench for strela_input_stream_node against an address/data reference model.
module tb_strela_input_stream_node;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i;
  logic [31:0] base_addr_i;
  logic [15:0] size_i, stride_i;
  logic        mem_req_o, mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_rdata_i, data_o;
  logic        valid_o, ready_i, busy_o, done_o, stall_o;

  always #5 clk_i = ~clk_i;

  strela_input_stream_node #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk_i (clk_i), .rst_i (rst_i), .start_i (start_i),
    .base_addr_i (base_addr_i), .size_i (size_i), .stride_i (stride_i),
    .mem_req_o (mem_req_o), .mem_addr_o (mem_addr_o), .mem_gnt_i (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i), .mem_rdata_i (mem_rdata_i),
    .data_o (data_o), .valid_o (valid_o), .ready_i (ready_i),
    .busy_o (busy_o), .done_o (done_o), .stall_o (stall_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory contents are a fixed hash of the byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  logic [31:0] exp_addr[$];
  logic [31:0] rsp_q[$];
  int n_gnt, n_pop, n_req, rdy_low;
  int gnt_pct, rv_pct, rdy_pct;
  bit prev_wait, last_pop;
  logic [31:0] prev_addr;

  task automatic tick();
    @(negedge clk_i);
    start_i      = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    if (rsp_q.size() > 0 && $urandom_range(0, 99) < rv_pct) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rsp_q.pop_front();
    end
    mem_gnt_i = ($urandom_range(0, 99) < gnt_pct);
    if (rdy_low > 0) begin
      ready_i = 1'b0;
      rdy_low--;
    end else begin
      ready_i = ($urandom_range(0, 99) < rdy_pct);
    end
    #1;
    if (prev_wait) begin
      chk("req_hold", mem_req_o, 1);
      chk("addr_hold", mem_addr_o, prev_addr);
    end
    if (mem_req_o) n_req++;
    if (mem_req_o && mem_gnt_i) begin
      if (n_gnt < exp_addr.size()) chk("addr", mem_addr_o, exp_addr[n_gnt]);
      else chk("gnt_overrun", n_gnt + 1, exp_addr.size());
      rsp_q.push_back(mem_word(mem_addr_o));
      n_gnt++;
    end
    prev_wait = mem_req_o && !mem_gnt_i;
    prev_addr = mem_addr_o;
    if (last_pop) begin
      chk("done_after_pop", done_o, 1);
      chk("busy_after_pop", busy_o, 0);
      last_pop = 1'b0;
    end
    if (valid_o && ready_i) begin
      if (n_pop < exp_addr.size()) chk("data", data_o, mem_word(exp_addr[n_pop]));
      else chk("pop_overrun", n_pop + 1, exp_addr.size());
      n_pop++;
      if (n_pop == exp_addr.size()) last_pop = 1'b1;
    end
  endtask

  task automatic run_xfer(input logic [31:0] base, input logic [15:0] size, input logic [15:0] stride,
                          input int gp, input int rp, input int yp, input int low_n,
                          input int restart_at, input bit bp, output int cycles);
    int  words;
    bit  done_seen;
    words = int'(size >> 2);
    exp_addr.delete();
    rsp_q.delete();
    for (int k = 0; k < words; k++) exp_addr.push_back(base + 32'(k) * {16'h0, stride});
    n_gnt = 0; n_pop = 0; n_req = 0;
    prev_wait = 1'b0; last_pop = 1'b0;
    gnt_pct = gp; rv_pct = rp; rdy_pct = yp; rdy_low = low_n;
    done_seen = 1'b0;
    cycles = -1;
    @(negedge clk_i);
    base_addr_i = base; size_i = size; stride_i = stride;
    start_i = 1'b1; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c == 0 && words > 0) begin
        chk("first_req", mem_req_o, 1);
        chk("first_addr", mem_addr_o, base);
      end
      if (bp && c == 19) begin
        chk("bp_granted", n_gnt, 4);
        chk("bp_req_low", mem_req_o, 0);
        chk("bp_stall", stall_o, 1);
      end
      if (c == restart_at) begin
        start_i = 1'b1;
        base_addr_i = base ^ 32'h0F00_0000;
        size_i = 16'd200;
        stride_i = stride + 16'd4;
      end
      if (done_o && !busy_o) begin
        done_seen = 1'b1;
        cycles = c + 1;
        break;
      end
    end
    chk("done_seen", done_seen, 1);
    chk("gnt_count", n_gnt, words);
    chk("pop_count", n_pop, words);
    chk("valid_idle", valid_o, 0);
    chk("stall_idle", stall_o, 0);
  endtask

  int cyc;

  initial begin
    rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; size_i = '0; stride_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_req", mem_req_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_stall", stall_o, 0);
    rst_i = 1'b0;

    // Full-rate transfer
    run_xfer(32'h8000_0000, 16'd80, 16'd4, 100, 100, 100, 0, -1, 1'b0, cyc);

    // Zero-length transfer
    run_xfer(32'h1234_5678, 16'd3, 16'd4, 100, 100, 100, 0, -1, 1'b0, cyc);
    chk("zero_no_req", n_req, 0);
    chk("zero_done_fast", (cyc >= 1 && cyc <= 2), 1);

    // CGRA back-pressure bounds outstanding reads to the FIFO depth
    run_xfer(32'h0000_2000, 16'd40, 16'd4, 100, 100, 100, 20, -1, 1'b1, cyc);

    // Address wrap
    run_xfer(32'hFFFF_FFF8, 16'd16, 16'd4, 100, 100, 100, 0, -1, 1'b0, cyc);

    // Random grant stalls with an ignored second start
    run_xfer(32'h4000_0100, 16'd64, 16'd12, 40, 60, 70, 0, 5, 1'b0, cyc);

    // Stride zero re-reads one address
    run_xfer(32'h0000_0400, 16'd24, 16'd0, 60, 50, 60, 0, -1, 1'b0, cyc);

    for (int i = 0; i < 5; i++) begin
      run_xfer($urandom, 16'($urandom_range(0, 120)), 16'($urandom_range(0, 40)),
               $urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(30, 100),
               0, -1, 1'b0, cyc);
    end

    // Reset with two reads outstanding, then stale responses
    exp_addr.delete(); rsp_q.delete();
    for (int k = 0; k < 10; k++) exp_addr.push_back(32'h0000_1000 + 32'(k) * 32'd8);
    n_gnt = 0; n_pop = 0; n_req = 0; prev_wait = 1'b0; last_pop = 1'b0;
    gnt_pct = 100; rv_pct = 0; rdy_pct = 100; rdy_low = 0;
    @(negedge clk_i);
    base_addr_i = 32'h0000_1000; size_i = 16'd40; stride_i = 16'd8; start_i = 1'b1;
    for (int c = 0; c < 10 && n_gnt < 2; c++) tick();
    chk("rst_outstanding", n_gnt, 2);
    @(negedge clk_i);
    rst_i = 1'b1; mem_gnt_i = 1'b0; start_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = $urandom;
    end
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    #1;
    chk("stale_valid", valid_o, 0);
    chk("stale_busy", busy_o, 0);
    chk("stale_done", done_o, 0);
    chk("stale_req", mem_req_o, 0);
    @(negedge clk_i);
    #1;
    chk("stale_valid2", valid_o, 0);
    prev_wait = 1'b0;

    // Recovery after abort
    run_xfer(32'h0000_3000, 16'd32, 16'd4, 80, 80, 80, 0, -1, 1'b0, cyc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
